// File: rtl/melody_trigger.sv
// melody_trigger: turns single-cycle play requests into timed start_melody
// windows for a melody player, with a guard gap between back-to-back plays.
//
// Parameters
//   PLAY_TICKS  clk cycles start_melody is held high per play (1..2^32-1)
//   GAP_TICKS   clk cycles start_melody is held low between plays (1..2^32-1)
//
// Ports
//   clk           system clock (1 MHz), single clock domain
//   rst           synchronous active-high reset
//   event_req     play request, one request per high cycle (no edge detect)
//   cancel        abort current play and flush all pending requests
//   start_melody  registered level to the player's start input
//   busy          registered, high while playing or in the guard gap
//   done          one-cycle pulse when a play window ends
//   pend_cnt      queued requests waiting to play (0..3)
//   overflow      one-cycle pulse when a request is dropped
//
// Configuration
//   MELODY_TRIGGER_QUEUE_EN  when defined, requests arriving during a play or
//                            gap are queued (depth 3); otherwise they are
//                            dropped with an overflow pulse and pend_cnt
//                            stays 0.

module melody_trigger #(
   parameter int unsigned PLAY_TICKS = 4000000,
   parameter int unsigned GAP_TICKS  = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       event_req,
   input  logic       cancel,
   output logic       start_melody,
   output logic       busy,
   output logic       done,
   output logic [1:0] pend_cnt,
   output logic       overflow
);

   localparam int unsigned CNT_W  = 32;
   localparam int unsigned PEND_W = 2;

   // Terminal counts: the counter starts at 0 on phase entry, so a phase of
   // N cycles ends on the edge where the counter has reached N-1.
   localparam logic [CNT_W-1:0]  PLAY_LAST = CNT_W'(PLAY_TICKS - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_TICKS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(3);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   tick;
   logic [CNT_W-1:0]   tick_nx;
   logic [PEND_W-1:0]  pend_nx;
   logic               start_nx;
   logic               busy_nx;
   logic               done_nx;
   logic               ovf_nx;

   logic               play_end;
   logic               gap_end;

   // Phase-end detection uses >= so the counter can never run past its
   // terminal count and a tick parameter of 1 gives a one-cycle phase.
   assign play_end = (tick >= PLAY_LAST);
   assign gap_end  = (tick >= GAP_LAST);

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tick         <= '0;
         pend_cnt     <= '0;
         start_melody <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         state        <= state_nx;
         tick         <= tick_nx;
         pend_cnt     <= pend_nx;
         start_melody <= start_nx;
         busy         <= busy_nx;
         done         <= done_nx;
         overflow     <= ovf_nx;
      end
   end

   // Next-state, counter, queue and output decode.
   always_comb begin
      state_nx = state;
      tick_nx  = tick;
      pend_nx  = pend_cnt;
      done_nx  = 1'b0;
      ovf_nx   = 1'b0;

      if (cancel) begin
         // Cancel flushes everything and swallows any same-edge request.
         state_nx = IDLE;
         tick_nx  = '0;
         pend_nx  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (event_req) begin
                  state_nx = PLAY;
                  tick_nx  = '0;
               end
            end

            PLAY: begin
               if (play_end) begin
                  state_nx = GAP;
                  tick_nx  = '0;
                  done_nx  = 1'b1;
               end else begin
                  tick_nx = tick + CNT_W'(1);
               end
`ifdef MELODY_TRIGGER_QUEUE_EN
               if (event_req) begin
                  if (pend_cnt != PEND_MAX) begin
                     pend_nx = pend_cnt + PEND_W'(1);
                  end else begin
                     ovf_nx = 1'b1;
                  end
               end
`else
               ovf_nx = event_req;
`endif
            end

            GAP: begin
               if (gap_end) begin
                  tick_nx = '0;
`ifdef MELODY_TRIGGER_QUEUE_EN
                  // A request landing on the expiry edge is queued and the
                  // head of the queue dequeued in the same edge, so a full
                  // queue stays full without overflowing. With an empty
                  // queue the fresh request plays directly instead of being
                  // stranded in the queue while idle.
                  if ((pend_cnt != '0) || event_req) begin
                     state_nx = PLAY;
                     if ((pend_cnt != '0) && !event_req) begin
                        pend_nx = pend_cnt - PEND_W'(1);
                     end
                  end else begin
                     state_nx = IDLE;
                  end
`else
                  state_nx = IDLE;
                  ovf_nx   = event_req;
`endif
               end else begin
                  tick_nx = tick + CNT_W'(1);
`ifdef MELODY_TRIGGER_QUEUE_EN
                  if (event_req) begin
                     if (pend_cnt != PEND_MAX) begin
                        pend_nx = pend_cnt + PEND_W'(1);
                     end else begin
                        ovf_nx = 1'b1;
                     end
                  end
`else
                  ovf_nx = event_req;
`endif
               end
            end

            default: begin
               state_nx = IDLE;
               tick_nx  = '0;
               pend_nx  = '0;
            end
         endcase
      end

`ifndef MELODY_TRIGGER_QUEUE_EN
      // No queue in this build: the pending count is held at zero.
      pend_nx = '0;
`endif

      // Outputs are registered copies of the decoded next state.
      start_nx = (state_nx == PLAY);
      busy_nx  = (state_nx != IDLE);
   end

endmodule

// File: tb/tb_melody_trigger.sv
// Self-checking bench for melody_trigger with PLAY_TICKS=10, GAP_TICKS=3.
// A phase/remaining-cycles model predicts every output after every edge;
// directed scenarios add hand-computed literal checks. Works for both builds
// (MELODY_TRIGGER_QUEUE_EN defined or not).

module tb_melody_trigger;

   localparam int unsigned PLAY_T = 10;
   localparam int unsigned GAP_T  = 3;
`ifdef MELODY_TRIGGER_QUEUE_EN
   localparam bit QUEUE_EN = 1'b1;
`else
   localparam bit QUEUE_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       event_req;
   logic       cancel;
   logic       start_melody;
   logic       busy;
   logic       done;
   logic [1:0] pend_cnt;
   logic       overflow;

   int checks;
   int errors;
   int edge_no;

   // Model: phase 0=idle 1=playing 2=gap, m_left = cycles left in phase.
   int   m_phase;
   int   m_left;
   int   m_pend;
   logic m_done;
   logic m_ovf;
   bit   model_valid;

   melody_trigger #(
      .PLAY_TICKS(PLAY_T),
      .GAP_TICKS (GAP_T)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .event_req   (event_req),
      .cancel      (cancel),
      .start_melody(start_melody),
      .busy        (busy),
      .done        (done),
      .pend_cnt    (pend_cnt),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (after edge %0d)", name, act, exp, edge_no);
      end
   endtask

   task automatic model_req(input logic e);
      if (e) begin
         if (QUEUE_EN && m_pend < 3) m_pend++;
         else m_ovf = 1'b1;
      end
   endtask

   // Advance the model by one edge given the inputs present at that edge.
   task automatic model_step(input logic r, input logic e, input logic c);
      m_done = 1'b0;
      m_ovf  = 1'b0;
      if (r || c) begin
         m_phase = 0;
         m_left  = 0;
         m_pend  = 0;
         if (r) model_valid = 1'b1;
      end else begin
         case (m_phase)
            0: if (e) begin
                  m_phase = 1;
                  m_left  = PLAY_T;
               end
            1: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = 2;
                     m_left  = GAP_T;
                     m_done  = 1'b1;
                  end
                  model_req(e);
               end
            default: begin
                  m_left--;
                  if (m_left == 0) begin
                     if (QUEUE_EN && (m_pend > 0 || e)) begin
                        m_phase = 1;
                        m_left  = PLAY_T;
                        if (m_pend > 0 && !e) m_pend--;
                     end else begin
                        m_phase = 0;
                        if (e) m_ovf = 1'b1;
                     end
                  end else begin
                     model_req(e);
                  end
               end
         endcase
      end
   endtask

   // Drive one edge's inputs, take the edge, update the model.
   task automatic drive_edge(input logic r, input logic e, input logic c);
      rst       = r;
      event_req = e;
      cancel    = c;
      @(posedge clk);
      model_step(r, e, c);
      #1;
      rst       = 1'b0;
      event_req = 1'b0;
      cancel    = 1'b0;
      edge_no++;
   endtask

   // Idle up to edge n-1, then apply the given inputs at edge n.
   task automatic go(input int n, input logic r, input logic e, input logic c);
      while (edge_no < n - 1) drive_edge(1'b0, 1'b0, 1'b0);
      drive_edge(r, e, c);
   endtask

   task automatic begin_test();
      edge_no = -1;
      drive_edge(1'b1, 1'b0, 1'b0);
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         chk("start_melody", 32'(start_melody), 32'(m_phase == 1));
         chk("busy",         32'(busy),         32'(m_phase != 0));
         chk("done",         32'(done),         32'(m_done));
         chk("overflow",     32'(overflow),     32'(m_ovf));
         chk("pend_cnt",     32'(pend_cnt),     32'(m_pend));
      end
   end

   initial begin
      checks      = 0;
      errors      = 0;
      edge_no     = 0;
      m_phase     = 0;
      m_left      = 0;
      m_pend      = 0;
      m_done      = 1'b0;
      m_ovf       = 1'b0;
      model_valid = 1'b0;
      rst         = 1'b0;
      event_req   = 1'b0;
      cancel      = 1'b0;
      @(negedge clk);

      // Single request: high for edges 5..14, done after 15, idle after 18.
      begin_test();
      chk("rst_start", 32'(start_melody), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_ovf",   32'(overflow), 0);
      chk("rst_pend",  32'(pend_cnt), 0);
      go(4, 1'b0, 1'b0, 1'b0);
      chk("t1_start_e4", 32'(start_melody), 0);
      go(5, 1'b0, 1'b1, 1'b0);
      chk("t1_start_e5", 32'(start_melody), 1);
      chk("t1_busy_e5",  32'(busy), 1);
      go(14, 1'b0, 1'b0, 1'b0);
      chk("t1_start_e14", 32'(start_melody), 1);
      go(15, 1'b0, 1'b0, 1'b0);
      chk("t1_start_e15", 32'(start_melody), 0);
      chk("t1_done_e15",  32'(done), 1);
      go(16, 1'b0, 1'b0, 1'b0);
      chk("t1_done_e16", 32'(done), 0);
      go(17, 1'b0, 1'b0, 1'b0);
      chk("t1_busy_e17", 32'(busy), 1);
      go(18, 1'b0, 1'b0, 1'b0);
      chk("t1_busy_e18", 32'(busy), 0);
      go(22, 1'b0, 1'b0, 1'b0);

      // Five requests at 5,7,8,9,10.
      begin_test();
      go(5, 1'b0, 1'b1, 1'b0);
      go(7, 1'b0, 1'b1, 1'b0);
`ifndef MELODY_TRIGGER_QUEUE_EN
      chk("t2_ovf_e7",  32'(overflow), 1);
      chk("t2_pend_e7", 32'(pend_cnt), 0);
`endif
      go(8, 1'b0, 1'b1, 1'b0);
      go(9, 1'b0, 1'b1, 1'b0);
      go(10, 1'b0, 1'b1, 1'b0);
`ifdef MELODY_TRIGGER_QUEUE_EN
      chk("t2_pend_e10", 32'(pend_cnt), 3);
      chk("t2_ovf_e10",  32'(overflow), 1);
      go(11, 1'b0, 1'b0, 1'b0);
      chk("t2_ovf_e11", 32'(overflow), 0);
      go(18, 1'b0, 1'b0, 1'b0);
      chk("t2_start_e18", 32'(start_melody), 1);
      chk("t2_pend_e18",  32'(pend_cnt), 2);
      go(44, 1'b0, 1'b0, 1'b0);
      chk("t2_start_e44", 32'(start_melody), 1);
      chk("t2_pend_e44",  32'(pend_cnt), 0);
      go(56, 1'b0, 1'b0, 1'b0);
      chk("t2_busy_e56", 32'(busy), 1);
      go(57, 1'b0, 1'b0, 1'b0);
      chk("t2_busy_e57", 32'(busy), 0);
`else
      go(18, 1'b0, 1'b0, 1'b0);
      chk("t2_busy_e18", 32'(busy), 0);
`endif
      go(62, 1'b0, 1'b0, 1'b0);

      // Requests at 5 and 8.
      begin_test();
      go(5, 1'b0, 1'b1, 1'b0);
      go(8, 1'b0, 1'b1, 1'b0);
`ifdef MELODY_TRIGGER_QUEUE_EN
      chk("t3_pend_e8", 32'(pend_cnt), 1);
      chk("t3_ovf_e8",  32'(overflow), 0);
      go(18, 1'b0, 1'b0, 1'b0);
      chk("t3_start_e18", 32'(start_melody), 1);
`else
      chk("t3_ovf_e8",  32'(overflow), 1);
      chk("t3_pend_e8", 32'(pend_cnt), 0);
      go(18, 1'b0, 1'b0, 1'b0);
      chk("t3_busy_e18", 32'(busy), 0);
`endif
      go(35, 1'b0, 1'b0, 1'b0);

      // Cancel mid-play, then cancel racing a request in idle and in play.
      begin_test();
      go(5, 1'b0, 1'b1, 1'b0);
      go(9, 1'b0, 1'b0, 1'b1);
      chk("t4_start_e9", 32'(start_melody), 0);
      chk("t4_busy_e9",  32'(busy), 0);
      chk("t4_pend_e9",  32'(pend_cnt), 0);
      go(15, 1'b0, 1'b0, 1'b0);
      chk("t4_done_e15", 32'(done), 0);
      go(17, 1'b0, 1'b1, 1'b1);
      chk("t4_busy_e17", 32'(busy), 0);
      chk("t4_ovf_e17",  32'(overflow), 0);
      go(20, 1'b0, 1'b1, 1'b0);
      go(22, 1'b0, 1'b1, 1'b1);
      chk("t4_busy_e22", 32'(busy), 0);
      chk("t4_ovf_e22",  32'(overflow), 0);
      go(30, 1'b0, 1'b0, 1'b0);

      // Full queue plus a request on the gap-expiry edge.
      begin_test();
      go(5, 1'b0, 1'b1, 1'b0);
      go(7, 1'b0, 1'b1, 1'b0);
      go(8, 1'b0, 1'b1, 1'b0);
      go(9, 1'b0, 1'b1, 1'b0);
      go(18, 1'b0, 1'b1, 1'b0);
`ifdef MELODY_TRIGGER_QUEUE_EN
      chk("t5_pend_e18",  32'(pend_cnt), 3);
      chk("t5_ovf_e18",   32'(overflow), 0);
      chk("t5_start_e18", 32'(start_melody), 1);
`else
      chk("t5_ovf_e18",  32'(overflow), 1);
      chk("t5_busy_e18", 32'(busy), 0);
`endif
      go(75, 1'b0, 1'b0, 1'b0);

      // Reset mid-gap with a request on the same edge.
      begin_test();
      go(5, 1'b0, 1'b1, 1'b0);
      go(7, 1'b0, 1'b1, 1'b0);
      go(8, 1'b0, 1'b1, 1'b0);
      go(16, 1'b0, 1'b0, 1'b0);
`ifdef MELODY_TRIGGER_QUEUE_EN
      chk("t6_pend_e16", 32'(pend_cnt), 2);
`endif
      go(17, 1'b1, 1'b1, 1'b0);
      chk("t6_start_e17", 32'(start_melody), 0);
      chk("t6_busy_e17",  32'(busy), 0);
      chk("t6_done_e17",  32'(done), 0);
      chk("t6_ovf_e17",   32'(overflow), 0);
      chk("t6_pend_e17",  32'(pend_cnt), 0);
      go(20, 1'b0, 1'b0, 1'b0);
      chk("t6_busy_e20", 32'(busy), 0);

      // Request held high for four cycles counts as four requests.
      begin_test();
      go(5, 1'b0, 1'b1, 1'b0);
      go(6, 1'b0, 1'b1, 1'b0);
      go(7, 1'b0, 1'b1, 1'b0);
      go(8, 1'b0, 1'b1, 1'b0);
`ifdef MELODY_TRIGGER_QUEUE_EN
      chk("t7_pend_e8", 32'(pend_cnt), 3);
      chk("t7_ovf_e8",  32'(overflow), 0);
`else
      chk("t7_ovf_e8",  32'(overflow), 1);
`endif
      go(9, 1'b0, 1'b1, 1'b0);
      chk("t7_ovf_e9", 32'(overflow), 1);
      go(70, 1'b0, 1'b0, 1'b0);

      // Request on gap expiry with nothing queued.
      begin_test();
      go(5, 1'b0, 1'b1, 1'b0);
      go(18, 1'b0, 1'b1, 1'b0);
      go(40, 1'b0, 1'b0, 1'b0);

      model_valid = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
